// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings, byte and timeout widths,
// and a small modular-add helper used by round-robin pickers.
package uart_tx_arb_pkg;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;

    // (a + b) mod n for 0 <= a, b < n, without a divider
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or above rr_ptr,
// wrapping modulo N_REQ.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // Scan from lowest priority to highest so the highest-priority hit is written last
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_add(int'(rr_ptr), i, N_REQ)]) begin
                id = ID_W'(wrap_add(int'(rr_ptr), i, N_REQ));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one UART TX engine among N_REQ requesters, one byte at a
// time, with packet locking and a completion timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; pick next requester round-robin from rr_ptr
// ST_ISSUE | owner granted; start the engine once tx_busy is low
// ST_WAIT  | byte in flight; wait for tx_end or timeout expiry
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*BYTE_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    input  logic                      tx_busy,
    input  logic                      tx_end,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [STATE_W-1:0] state;
    logic [ID_W-1:0]    rr_ptr;
    logic               lock;
    logic [CNT_W-1:0]   cnt;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    next_ptr;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .id     (pick_id)
    );

    assign next_ptr = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            cnt      <= '0;
            grant_id <= '0;
            ack      <= '0;
            done     <= '0;
            err      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            ack      <= '0;
            done     <= '0;
            err      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_id;
                        state    <= ST_ISSUE;
                        busy     <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!tx_busy) begin
                        tx_start      <= 1'b1;
                        tx_data       <= req_data[int'(grant_id)*BYTE_W +: BYTE_W];
                        ack[grant_id] <= 1'b1;
                        lock          <= !req_last[grant_id];
                        cnt           <= '0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // tx_end takes priority over a coincident timeout expiry
                    if (tx_end) begin
                        done[grant_id] <= 1'b1;
                        if (lock && req[grant_id]) begin
                            state <= ST_ISSUE;
                        end else begin
                            rr_ptr <= next_ptr;
                            lock   <= 1'b0;
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err[grant_id] <= 1'b1;
                        rr_ptr        <= next_ptr;
                        lock          <= 1'b0;
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
